// File: rtl/dplbuf_blk_sched.sv
// rtl/dplbuf_blk_sched.sv - round-robin DPL DMA buffer block scheduler
// Grants one 4KB block at a time, issues the write-pointer increment, then settles.
module dplbuf_blk_sched #(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 3,
  parameter int FREE_MIN   = 1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iRST_PTR,
  input  logic [NUM_REQ-1:0] iREQ,
  input  logic               iBLK_DONE,
  input  logic [31:0]        iDPLBUF_FREE,
  input  logic               iDPLBUF_FULL,
  input  logic [31:0]        iDPLBUF_WR_PTR,
  output logic [NUM_REQ-1:0] oGNT,
  output logic [31:0]        oBLK_PFN,
  output logic               oDPLBUF_INC_WR_PTR,
  output logic               oBUSY
);

  localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RETIRE, ST_SETTLE} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [31:0]        r_pfn, w_pfn_nxt;
  logic               r_inc, w_inc_nxt;
  logic               r_busy;
  logic [RRW-1:0]     r_rr_last, w_rr_last_nxt;
  logic [CW-1:0]      r_settle_cnt, w_settle_cnt_nxt;
  logic               w_space;
  logic               w_found;
  logic [RRW-1:0]     w_winner;

  // Scan from farthest to nearest offset so the requester closest after rr_last wins.
  function automatic logic [RRW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [RRW-1:0] last);
    logic [RRW:0] res;
    int           idx;
    res = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(last) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx[RRW-1:0]]) res = {1'b1, idx[RRW-1:0]};
    end
    return res;
  endfunction

  // FULL overrides FREE so an all-ones FREE wrap can never produce a grant.
  assign w_space             = !iDPLBUF_FULL && (iDPLBUF_FREE >= 32'(FREE_MIN));
  assign {w_found, w_winner} = rr_pick(iREQ, r_rr_last);

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = r_gnt;
    w_pfn_nxt        = r_pfn;
    w_inc_nxt        = 1'b0;
    w_rr_last_nxt    = r_rr_last;
    w_settle_cnt_nxt = r_settle_cnt;
    if (iRST_PTR) begin
      w_state_nxt      = ST_IDLE;
      w_gnt_nxt        = '0;
      w_settle_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found && w_space) begin
            w_gnt_nxt           = '0;
            w_gnt_nxt[w_winner] = 1'b1;
            w_pfn_nxt           = iDPLBUF_WR_PTR;
            w_rr_last_nxt       = w_winner;
            w_state_nxt         = ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (iBLK_DONE) begin
            w_gnt_nxt   = '0;
            w_inc_nxt   = 1'b1;
            w_state_nxt = ST_RETIRE;
          end
        end
        ST_RETIRE: begin
          w_settle_cnt_nxt = CW'(SETTLE_CYC - 1);
          w_state_nxt      = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == '0) w_state_nxt = ST_IDLE;
          else                    w_settle_cnt_nxt = r_settle_cnt - 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_pfn        <= '0;
      r_inc        <= 1'b0;
      r_busy       <= 1'b0;
      r_rr_last    <= RRW'(NUM_REQ - 1);
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_pfn        <= w_pfn_nxt;
      r_inc        <= w_inc_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_rr_last    <= w_rr_last_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
    end
  end

  assign oGNT               = r_gnt;
  assign oBLK_PFN           = r_pfn;
  assign oDPLBUF_INC_WR_PTR = r_inc;
  assign oBUSY              = r_busy;

  a_done_only_in_grant: assert property (@(posedge iCLK) disable iff (iRST)
    iBLK_DONE |-> (r_state == ST_GRANT))
    else $warning("dplbuf_blk_sched: iBLK_DONE outside GRANT ignored");

endmodule

// File: tb/tb_dplbuf_blk_sched.sv
// tb/tb_dplbuf_blk_sched.sv - randomized and directed bench for dplbuf_blk_sched
module tb_dplbuf_blk_sched;

  localparam int NREQ   = 4;
  localparam int SETTLE = 3;
  localparam int FMIN   = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            rst_ptr;
  logic [NREQ-1:0] req;
  logic            done;
  logic [31:0]     free;
  logic            full;
  logic [31:0]     wr_ptr;
  logic [NREQ-1:0] gnt;
  logic [31:0]     pfn;
  logic            inc;
  logic            busy;

  logic [NREQ-1:0] req2;
  logic [31:0]     free2;
  logic [NREQ-1:0] gnt2;
  logic [31:0]     pfn2;
  logic            inc2;
  logic            busy2;

  int n_checks = 0;
  int n_errors = 0;

  int          m_owner;
  int          m_last;
  int          m_cool;
  logic        m_inc;
  logic [31:0] m_pfn;

  always #5 clk = ~clk;

  dplbuf_blk_sched #(.NUM_REQ(NREQ), .SETTLE_CYC(SETTLE), .FREE_MIN(FMIN)) u_dut (
    .iCLK(clk), .iRST(rst), .iRST_PTR(rst_ptr), .iREQ(req), .iBLK_DONE(done),
    .iDPLBUF_FREE(free), .iDPLBUF_FULL(full), .iDPLBUF_WR_PTR(wr_ptr),
    .oGNT(gnt), .oBLK_PFN(pfn), .oDPLBUF_INC_WR_PTR(inc), .oBUSY(busy));

  dplbuf_blk_sched #(.NUM_REQ(NREQ), .SETTLE_CYC(SETTLE), .FREE_MIN(2)) u_dut_fmin2 (
    .iCLK(clk), .iRST(rst), .iRST_PTR(1'b0), .iREQ(req2), .iBLK_DONE(1'b0),
    .iDPLBUF_FREE(free2), .iDPLBUF_FULL(1'b0), .iDPLBUF_WR_PTR(32'h0000_0ABC),
    .oGNT(gnt2), .oBLK_PFN(pfn2), .oDPLBUF_INC_WR_PTR(inc2), .oBUSY(busy2));

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return 32'(i);
    return 32'hFF;
  endfunction

  // Block-level view: who owns the buffer, and how many cycles until arbitration is allowed again.
  task automatic model_reset();
    m_owner = -1; m_last = NREQ - 1; m_cool = 0; m_inc = 1'b0; m_pfn = '0;
  endtask

  task automatic model_step();
    m_inc = 1'b0;
    if (rst_ptr) begin
      m_owner = -1; m_cool = 0;
    end else if (m_owner >= 0) begin
      if (done) begin
        m_owner = -1; m_inc = 1'b1; m_cool = SETTLE + 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (!full && free >= 32'(FMIN)) begin
      for (int off = 1; off <= NREQ; off++) begin
        if (req[(m_last + off) % NREQ]) begin
          m_owner = (m_last + off) % NREQ;
          break;
        end
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_pfn = wr_ptr;
      end
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    expect_eq("gnt", 32'(gnt), 32'(eg));
    expect_eq("inc", 32'(inc), 32'(m_inc));
    expect_eq("busy", 32'(busy), 32'(m_owner >= 0 || m_inc || m_cool > 0));
    if (m_owner >= 0) expect_eq("pfn", pfn, m_pfn);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    model_step();
    compare();
    @(negedge clk);
  endtask

  task automatic full_reset();
    rst = 1'b1;
    #1;
    model_reset();
    expect_eq("rst_gnt", 32'(gnt), 32'h0);
    expect_eq("rst_inc", 32'(inc), 32'h0);
    expect_eq("rst_busy", 32'(busy), 32'h0);
    expect_eq("rst_pfn", pfn, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_ptr = 1'b0; req = '0; done = 1'b0;
    free = 32'd10; full = 1'b0; wr_ptr = 32'h100; req2 = '0; free2 = 32'd1;
    model_reset();
    @(negedge clk); @(negedge clk);
    full_reset();

    // single requester, then settle window
    req = 4'b0001; free = 32'd10; wr_ptr = 32'h100;
    cyc();
    expect_eq("t1_gnt", 32'(gnt), 32'h1);
    expect_eq("t1_pfn", pfn, 32'h100);
    done = 1'b1; cyc(); done = 1'b0;
    expect_eq("t1_gnt_clr", 32'(gnt), 32'h0);
    expect_eq("t1_inc", 32'(inc), 32'h1);
    cyc();
    expect_eq("t1_inc_width", 32'(inc), 32'h0);
    repeat (3) begin
      cyc();
      expect_eq("t1_settle_nognt", 32'(gnt), 32'h0);
    end
    cyc();
    expect_eq("t1_regrant", 32'(gnt), 32'h1);
    req = '0; done = 1'b1; cyc(); done = 1'b0;
    repeat (6) cyc();

    // strict rotation from reset
    full_reset();
    req = 4'b1111; free = 32'd100;
    for (int b = 0; b < 8; b++) begin
      for (int w = 0; w < 20 && gnt == '0; w++) cyc();
      expect_eq("t2_rr_order", onehot_idx(gnt), 32'(b % NREQ));
      done = 1'b1; cyc(); done = 1'b0;
    end
    req = '0;
    repeat (6) cyc();

    // FULL overrides an all-ones FREE
    req = 4'b0010; full = 1'b1; free = 32'hFFFF_FFFF;
    repeat (4) begin
      cyc();
      expect_eq("t3_full_nognt", 32'(gnt), 32'h0);
    end
    full = 1'b0; free = 32'd1;
    cyc();
    expect_eq("t3_gnt", 32'(gnt), 32'h2);
    req = '0; rst_ptr = 1'b1; cyc(); rst_ptr = 1'b0;

    // FREE_MIN=2 instance
    req2 = 4'b0001; free2 = 32'd1;
    repeat (3) begin
      cyc();
      expect_eq("t4_fmin_nognt", 32'(gnt2), 32'h0);
    end
    free2 = 32'd2;
    cyc();
    expect_eq("t4_fmin_gnt", 32'(gnt2), 32'h1);
    expect_eq("t4_fmin_pfn", pfn2, 32'h0000_0ABC);

    // abort with simultaneous done, rotation resumes after the aborted grantee
    full_reset();
    req = 4'b0100; free = 32'd5;
    cyc();
    expect_eq("t5_gnt", 32'(gnt), 32'h4);
    rst_ptr = 1'b1; done = 1'b1; cyc(); rst_ptr = 1'b0; done = 1'b0;
    expect_eq("t5_abort_gnt", 32'(gnt), 32'h0);
    expect_eq("t5_abort_inc", 32'(inc), 32'h0);
    expect_eq("t5_abort_busy", 32'(busy), 32'h0);
    req = 4'b1111;
    cyc();
    expect_eq("t5_no_inc", 32'(inc), 32'h0);
    expect_eq("t5_resume", 32'(gnt), 32'h8);
    req = '0; rst_ptr = 1'b1; cyc(); rst_ptr = 1'b0;

    // spurious done in IDLE, grantee drops request mid-grant
    done = 1'b1; cyc(); done = 1'b0;
    expect_eq("t6_spurious_inc", 32'(inc), 32'h0);
    expect_eq("t6_spurious_busy", 32'(busy), 32'h0);
    req = 4'b0001;
    cyc();
    expect_eq("t6_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (3) begin
      cyc();
      expect_eq("t6_hold", 32'(gnt), 32'h1);
    end
    done = 1'b1; cyc(); done = 1'b0;
    expect_eq("t6_inc", 32'(inc), 32'h1);
    repeat (6) cyc();

    // randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(3, 0) == 0) req = NREQ'($urandom);
      case ($urandom_range(4, 0))
        0: free = 32'd0;
        1: free = 32'd1;
        2: free = 32'hFFFF_FFFF;
        default: free = $urandom;
      endcase
      full    = ($urandom_range(4, 0) == 0);
      wr_ptr  = $urandom;
      done    = (m_owner >= 0) && ($urandom_range(5, 0) == 0);
      rst_ptr = ($urandom_range(49, 0) == 0);
      if (n == 1000) begin
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        expect_eq("async_rst_gnt", 32'(gnt), 32'h0);
        expect_eq("async_rst_busy", 32'(busy), 32'h0);
        expect_eq("async_rst_inc", 32'(inc), 32'h0);
        @(negedge clk);
        rst = 1'b0;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
